// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg
// Shared types and constants for the SPI command/memory bridge.
//   state_t      : command FSM states
//   CMD_WR_BIT   : command byte bit selecting write (1) or read (0)
//   CMD_RSVD_BIT : reserved command bit; a set bit makes the frame ignored
//   TX_IDLE      : byte returned to the SPI receiver when nothing is being read
package spi_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DISCARD
  } state_t;

  localparam int CMD_WR_BIT   = 7;
  localparam int CMD_RSVD_BIT = 6;

  localparam logic [7:0] TX_IDLE = 8'h00;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchroniser for a single asynchronous level.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, loads RESET_VAL into both flops
//   d      : asynchronous input level
//   q      : synchronised level, 2-3 clk_i cycles behind d
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d,
  output logic q
);

  logic meta;

  // Classic back-to-back flop pair; the first stage may go metastable and
  // gets a full cycle to settle before q is used by downstream logic.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl
// Decodes the byte stream from spi_receiver into burst writes to and burst
// reads from the latch memory, and supplies the next byte to shift out.
//   clk_i      : system clock
//   rst_ni     : asynchronous active-low reset
//   enable_i   : command mode active; low forces the FSM idle
//   spi_cs_i   : raw SPI chip select (active low, asynchronous)
//   rx_data_i  : received byte, valid with rx_stb_i
//   rx_stb_i   : one-cycle received-byte strobe
//   tx_data_o  : next byte to shift out
//   mem_addr_o : memory address
//   mem_data_o : memory write data
//   mem_we_o   : memory write enable, one-cycle pulse
//   mem_data_i : memory read data (combinational read of mem_addr_o)
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              spi_cs_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_stb_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_data_i
);

  state_t            state_q, state_d;
  logic              cs_sync;
  logic              frame_end;
  logic              cmd_load, wr_req, rd_req;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] tx_q;
  logic              we_q;
  logic              rd_pend_q;

  sync_2ff #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d      (spi_cs_i),
    .q      (cs_sync)
  );

  // A high synchronised CS or leaving command mode ends the frame; it takes
  // priority over any strobe arriving in the same cycle.
  assign frame_end = cs_sync | ~enable_i;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: the first byte after IDLE is the command byte, everything
  // else is data until the frame ends.
  always_comb begin
    state_d = state_q;
    if (frame_end) begin
      state_d = IDLE;
    end else if (state_q == IDLE && rx_stb_i) begin
      if (rx_data_i[CMD_RSVD_BIT]) begin
        state_d = DISCARD;
      end else if (rx_data_i[CMD_WR_BIT]) begin
        state_d = WRITE;
      end else begin
        state_d = READ;
      end
    end
  end

  // Per-strobe actions. A read command also requests a prefetch so the first
  // data byte of the frame already carries mem[start].
  always_comb begin
    cmd_load = 1'b0;
    wr_req   = 1'b0;
    rd_req   = 1'b0;
    if (!frame_end && rx_stb_i) begin
      unique case (state_q)
        IDLE: begin
          cmd_load = 1'b1;
          rd_req   = ~rx_data_i[CMD_RSVD_BIT] & ~rx_data_i[CMD_WR_BIT];
        end
        WRITE:   wr_req = 1'b1;
        READ:    rd_req = 1'b1;
        DISCARD: ;
        default: ;
      endcase
    end
  end

  // Datapath. The address advances in the cycle after the write pulse or
  // after a read fetch, so address and data stay stable while they are used.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rd_pend_q <= 1'b0;
      tx_q      <= DATA_W'(TX_IDLE);
    end else begin
      we_q      <= wr_req;
      rd_pend_q <= rd_req;
      if (wr_req) begin
        wdata_q <= rx_data_i;
      end
      if (cmd_load) begin
        addr_q <= rx_data_i[ADDR_W-1:0];
      end else if (we_q || (rd_pend_q && !frame_end)) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
      if (frame_end) begin
        tx_q <= DATA_W'(TX_IDLE);
      end else if (rd_pend_q) begin
        tx_q <= mem_data_i;
      end
    end
  end

  // Gating with enable_i keeps the memory untouched the moment command mode
  // is left, even if a write pulse was already scheduled.
  assign mem_we_o   = we_q & enable_i;
  assign mem_addr_o = addr_q;
  assign mem_data_o = wdata_q;
  assign tx_data_o  = tx_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb_spi_mem_ctrl
// Self-checking bench for spi_mem_ctrl. A latch-memory model answers reads
// combinationally and takes writes on the clock; a frame-level reference
// model (ref_mem plus the command byte rules) predicts every write and
// every transmitted byte.
module tb_spi_mem_ctrl;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 64;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic              spi_cs;
  logic [DATA_W-1:0] rx_data;
  logic              rx_stb;
  logic [DATA_W-1:0] tx_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] frame_q [$];

  int wr_count     = 0;
  int n_compared   = 0;
  int n_mismatched = 0;

  spi_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .enable_i   (enable),
    .spi_cs_i   (spi_cs),
    .rx_data_i  (rx_data),
    .rx_stb_i   (rx_stb),
    .tx_data_o  (tx_data),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_wdata),
    .mem_we_o   (mem_we),
    .mem_data_i (mem_rdata)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Latch memory: combinational read, clocked write, plus a write counter so
  // frames can check how many writes they caused.
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_count      <= wr_count + 1;
    end
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sends one byte as a one-cycle strobe and samples the outputs one and two
  // cycles later, then leaves a gap so strobes stay well apart.
  task automatic applyStimulus(input logic [7:0] b,
                               output logic we1, output logic [5:0] a1,
                               output logic [7:0] d1, output logic [7:0] tx1,
                               output logic we2, output logic [7:0] tx2);
    @(negedge clk);
    rx_data = b;
    rx_stb  = 1'b1;
    @(negedge clk);
    rx_stb = 1'b0;
    we1 = mem_we;
    a1  = mem_addr;
    d1  = mem_wdata;
    tx1 = tx_data;
    @(negedge clk);
    we2 = mem_we;
    tx2 = tx_data;
    repeat (3) @(negedge clk);
  endtask

  // Runs the frame held in frame_q and checks it against the command rules:
  // write frames store byte k at start+k-1, read frames return mem[start+k]
  // two cycles after strobe k, discard frames do nothing.
  task automatic runFrame();
    logic [7:0] cmd;
    logic       we1, we2;
    logic [5:0] a1;
    logic [7:0] d1, tx1, tx2;
    int         start, wr_before, exp_wr, ea;
    bit         is_wr, is_rd;
    cmd       = frame_q[0];
    start     = int'(cmd[5:0]);
    is_wr     = !cmd[6] && cmd[7];
    is_rd     = !cmd[6] && !cmd[7];
    wr_before = wr_count;
    exp_wr    = 0;
    @(negedge clk);
    spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < frame_q.size(); k++) begin
      applyStimulus(frame_q[k], we1, a1, d1, tx1, we2, tx2);
      if (is_wr && k > 0) begin
        ea = (start + k - 1) % DEPTH;
        checkOutput("wr_we", 32'(we1), 1);
        checkOutput("wr_addr", 32'(a1), ea);
        checkOutput("wr_data", 32'(d1), 32'(frame_q[k]));
        ref_mem[ea] = frame_q[k];
        exp_wr++;
      end else begin
        checkOutput("no_we", 32'(we1), 0);
      end
      checkOutput("we_pulse_end", 32'(we2), 0);
      if (is_rd) begin
        checkOutput("tx_hold", 32'(tx1),
                    (k == 0) ? 0 : 32'(ref_mem[(start + k - 1) % DEPTH]));
        checkOutput("tx_read", 32'(tx2), 32'(ref_mem[(start + k) % DEPTH]));
      end else begin
        checkOutput("tx_idle", 32'(tx2), 0);
      end
    end
    spi_cs = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("tx_frame_end", 32'(tx_data), 0);
    checkOutput("frame_writes", 32'(wr_count - wr_before), exp_wr);
  endtask

  // Main sequence: reset, preload, directed frames, enable and reset cases,
  // random frames, final memory sweep.
  initial begin
    logic       we1, we2;
    logic [5:0] a1;
    logic [7:0] d1, tx1, tx2;
    int         wr_before, nbytes;
    logic [7:0] cmd;

    rst_n   = 1'b0;
    enable  = 1'b1;
    spi_cs  = 1'b1;
    rx_stb  = 1'b0;
    rx_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_we", 32'(mem_we), 0);
    checkOutput("rst_addr", 32'(mem_addr), 0);
    checkOutput("rst_data", 32'(mem_wdata), 0);
    checkOutput("rst_tx", 32'(tx_data), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    frame_q = {8'h80};
    for (int i = 0; i < DEPTH; i++) frame_q.push_back(8'($urandom));
    runFrame();

    frame_q = {8'h85, 8'h11, 8'h22};
    runFrame();
    frame_q = {8'hBF, 8'hAA, 8'hBB};
    runFrame();
    frame_q = {8'h05, 8'h00, 8'h00};
    runFrame();
    frame_q = {8'h40, 8'h77, 8'h88};
    runFrame();
    frame_q = {8'hA0, 8'h66};
    runFrame();
    frame_q = {8'h83, 8'h55};
    runFrame();
    frame_q = {8'h03, 8'h00};
    runFrame();

    wr_before = wr_count;
    enable = 1'b0;
    spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    applyStimulus(8'h80, we1, a1, d1, tx1, we2, tx2);
    checkOutput("en_cmd_we", 32'(we1), 0);
    applyStimulus(8'h99, we1, a1, d1, tx1, we2, tx2);
    checkOutput("en_data_we", 32'(we1), 0);
    checkOutput("en_tx", 32'(tx2), 0);
    spi_cs = 1'b1;
    repeat (4) @(negedge clk);
    enable = 1'b1;
    checkOutput("en_writes", 32'(wr_count - wr_before), 0);

    spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    applyStimulus(8'h8A, we1, a1, d1, tx1, we2, tx2);
    @(negedge clk);
    rx_data = 8'h5C;
    rx_stb  = 1'b1;
    @(negedge clk);
    rx_stb = 1'b0;
    checkOutput("pre_rst_we", 32'(mem_we), 1);
    wr_before = wr_count;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_we", 32'(mem_we), 0);
    checkOutput("midrst_addr", 32'(mem_addr), 0);
    checkOutput("midrst_data", 32'(mem_wdata), 0);
    checkOutput("midrst_tx", 32'(tx_data), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    spi_cs = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("midrst_writes", 32'(wr_count - wr_before), 0);

    for (int f = 0; f < 20; f++) begin
      cmd    = 8'($urandom);
      cmd[6] = ($urandom_range(3) == 0);
      nbytes = $urandom_range(5, 1);
      frame_q = {cmd};
      for (int i = 0; i < nbytes; i++) frame_q.push_back(8'($urandom));
      runFrame();
    end

    for (int i = 0; i < DEPTH; i++) begin
      checkOutput($sformatf("mem_final[%0d]", i), 32'(mem[i]), 32'(ref_mem[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/spi_mem_ctrl.md
# spi_mem_ctrl

SPI command/memory bridge between `spi_receiver` and `latch_mem`. It decodes the byte stream from `spi_receiver` into burst writes to the 64-word latch memory and burst reads from it. It also supplies the next transmit byte back to `spi_receiver`. It drives the command-mode address/data/write-enable path while `mode_i` = 0 and is idle otherwise.

## Interface
Parameters:
- `ADDR_W`, default 6: memory address width; the address wraps at `2**ADDR_W`.
- `DATA_W`, default 8: SPI word and memory word width.

Ports:
- `clk_i`  in  1  system clock; the block has a single clock domain.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `enable_i`  in  1  high while the top level is in command mode (`mode_i` = 0).
- `spi_cs_i`  in  1  raw SPI chip select, active low, asynchronous to `clk_i`.
- `rx_data_i`  in  DATA_W  received byte from `spi_receiver` `data_o`.
- `rx_stb_i`  in  1  one-cycle pulse; `rx_data_i` is valid.
- `tx_data_o`  out  DATA_W  next byte to shift out, connected to `spi_receiver` `data_i`.
- `mem_addr_o`  out  ADDR_W  memory address.
- `mem_data_o`  out  DATA_W  memory write data.
- `mem_we_o`  out  1  memory write enable, one-cycle pulse.
- `mem_data_i`  in  DATA_W  memory read data, valid one cycle after `mem_addr_o` changes.

## Operation
- A frame is the span of bytes between CS assertion and CS deassertion. The first byte of each frame is the command byte:
  - bit7 = 1: write; bit7 = 0: read.
  - bit6: reserved, must be 0.
  - bits5:0: start address.
- State machine `IDLE`, `WRITE`, `READ`, `DISCARD`:
  - IDLE + `rx_stb_i`, bit6 = 1 → DISCARD.
  - IDLE + `rx_stb_i`, bit6 = 0, bit7 = 1 → WRITE.
  - IDLE + `rx_stb_i`, bit6 = 0, bit7 = 0 → READ.
  - Each transition loads `addr` = bits5:0.
  - WRITE/READ/DISCARD → IDLE when the synchronised CS goes high (frame end) or `enable_i` = 0.
- WRITE: each `rx_stb_i` writes `rx_data_i` to `addr`, then increments `addr` modulo 64 (63 → 0). `tx_data_o` = 8'h00.
- READ: after the command byte and after every data byte, `tx_data_o` is loaded with `mem[addr]` and `addr` increments modulo 64. Data byte k (k ≥ 1) of the frame therefore shifts out `mem[start + k - 1]`.
- DISCARD: all bytes are ignored. `mem_we_o` stays 0 and `tx_data_o` = 8'h00.
- `enable_i` = 0: the FSM is forced to IDLE, `rx_stb_i` is ignored and `mem_we_o` is held at 0.
- Frame end in any state: FSM → IDLE and `tx_data_o` → 8'h00. The next `rx_stb_i` is decoded as a command byte.

## Timing
- Reset values:
  - FSM = IDLE.
  - `addr` = 0, so `mem_addr_o` = 0.
  - `mem_data_o` = 0, `mem_we_o` = 0, `tx_data_o` = 8'h00.
  - CS synchroniser flops = 1 (inactive).
- `spi_cs_i` passes through a 2-flop synchroniser. Frame end is taken on the synchronised high level, so it is seen 2–3 cycles after the pin goes high.
- Write, `rx_stb_i` in cycle N:
  - N+1: `mem_we_o` = 1, `mem_addr_o` = current `addr`, `mem_data_o` = byte.
  - N+2: `mem_we_o` = 0 and `addr` increments. Address and data remain stable during the `mem_we_o` cycle.
- Read, `rx_stb_i` in cycle N (command byte or data byte):
  - N+1: `mem_addr_o` presents the address (the start address for a command byte, the incremented `addr` for a data byte).
  - N+2: `tx_data_o` ← `mem_data_i`.
  - Latency from `rx_stb_i` to `tx_data_o` valid is 2 cycles. `spi_receiver` must not sample `data_i` earlier than 3 `clk_i` cycles after `stb_o`.
- `rx_stb_i` arrives at most once per 8 SCLK periods, which is always more than 3 cycles apart, so there is no stb overlap.
- Frame end and `rx_stb_i` in the same cycle: frame end wins and the byte is dropped.
- Reset mid-frame: all outputs return to reset values immediately. No partial write is issued after release.

## Structure
- Package `spi_mem_pkg` holds:
  - `state_t` enum {IDLE, WRITE, READ, DISCARD};
  - `CMD_WR_BIT` = 7, `CMD_RSVD_BIT` = 6;
  - `TX_IDLE` = 8'h00.
- Sub-module `sync_2ff` synchronises `spi_cs_i`; the reset value is 1.
- The FSM, address counter and tx register live in `spi_mem_ctrl`. The top level replaces the tied-off `spi_addr`/`spi_data_out` and feeds `tx_data_o` into `spi_receiver`.

## Test plan
- Write burst, frame 0x85, 0x11, 0x22: `mem_we_o` pulses twice, writing mem[5] = 0x11 and mem[6] = 0x22. The pulses come 1 cycle after each data stb, and none follows the command byte.
- Address wrap, frame 0xBF, 0xAA, 0xBB: mem[63] = 0xAA, then mem[0] = 0xBB.
- Read burst, after the first test, frame 0x05, 0x00, 0x00: `tx_data_o` = 0x11 two cycles after the command stb, then 0x22 two cycles after the first data stb.
- Reserved bit, frame 0x40, 0x77, 0x88: no `mem_we_o`, `tx_data_o` stays 0x00. The next frame's first byte is decoded as a command.
- CS high mid-write, then new frame 0x83, 0x55: the first byte of the new frame is taken as a command, so mem[3] = 0x55 and no write goes to the old address.
- `enable_i` = 0 during frame 0x80, 0x99: no `mem_we_o`. Asserting `rst_ni` low mid-frame returns all outputs to their reset values within the same cycle.
